// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding
// and default address/offset widths.
package pc_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_OFF_W  = 8;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_CALL,
    SEL_RET,
    SEL_HOLD
  } sel_e;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack. A push while full overwrites the oldest entry;
// a pop while empty changes nothing. Both cases raise a one-cycle pulse.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         overflow,
  output logic         underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  // wr_ptr is the next free slot; once full it also points at the oldest entry
  assign top       = mem[wr_ptr - PW'(1)];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign overflow  = push && !pop && full;
  assign underflow = pop && empty;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (pop) begin
      if (!empty) begin
        wr_ptr <= wr_ptr - PW'(1);
        count  <= count - CW'(1);
      end
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (!full)
        count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !pop)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-PC selection (ret > call > jump >
// branch > sequential), PC register and a sticky RAS error flag.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                 ADDR_W    = DEF_ADDR_W,
  parameter int                 OFF_W     = DEF_OFF_W,
  parameter int                 RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter int unsigned        INC       = 1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [OFF_W-1:0]  branch_off,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              call_en,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_next,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

  sel_e              sel;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] ras_top;
  logic              push;
  logic              pop;
  logic              overflow;
  logic              underflow;
  logic              err_q;

  assign pc_inc  = pc_q + INC_V;
  assign off_ext = ADDR_W'($signed(branch_off));

  // Selection ignores stall so pc_next always shows what the request would do
  always_comb begin
    sel = SEL_SEQ;
    if (ret_en)         sel = ras_empty ? SEL_HOLD : SEL_RET;
    else if (call_en)   sel = SEL_CALL;
    else if (jump_en)   sel = SEL_JMP;
    else if (branch_en) sel = SEL_BR;
  end

  always_comb begin
    pc_next = pc_inc;
    case (sel)
      SEL_BR:   pc_next = pc_q + off_ext;
      SEL_JMP:  pc_next = jump_addr;
      SEL_CALL: pc_next = jump_addr;
      SEL_RET:  pc_next = ras_top;
      SEL_HOLD: pc_next = pc_q;
      default:  pc_next = pc_inc;
    endcase
  end

  assign push = call_en && !ret_en && !stall;
  assign pop  = ret_en && !stall;

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .RST       (RST),
    .push      (push),
    .pop       (pop),
    .din       (pc_inc),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else if (!stall) begin
      pc_q  <= pc_next;
      err_q <= err_q | overflow | underflow;
    end
  end

  assign pc_out  = pc_q;
  assign ras_err = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (ADDR_W=8, RAS_DEPTH=4, RESET_VEC=0x10).
module tb_pc_unit;

  logic       clk;
  logic       RST;
  logic       stall;
  logic       branch_en;
  logic [7:0] branch_off;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       call_en;
  logic       ret_en;
  logic [7:0] pc_out;
  logic [7:0] pc_next;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_err;

  int testCount = 0;
  int failCount = 0;

  pc_unit #(
    .ADDR_W    (8),
    .OFF_W     (8),
    .RAS_DEPTH (4),
    .RESET_VEC (8'h10),
    .INC       (1)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .stall      (stall),
    .branch_en  (branch_en),
    .branch_off (branch_off),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .pc_out     (pc_out),
    .pc_next    (pc_next),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_err    (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request set, lets one rising edge pass and settles 1ns after it
  task automatic applyStimulus(input logic st, input logic rt, input logic cl,
                               input logic jp, input logic br,
                               input logic [7:0] addr, input logic [7:0] off);
    stall = st; ret_en = rt; call_en = cl; jump_en = jp; branch_en = br;
    jump_addr = addr; branch_off = off;
    @(posedge clk);
    #1;
    stall = 0; ret_en = 0; call_en = 0; jump_en = 0; branch_en = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    RST = 1; stall = 0; branch_en = 0; branch_off = 0; jump_en = 0;
    jump_addr = 0; call_en = 0; ret_en = 0;
    #12 RST = 0;
    #1;
    checkOutput("rst_pc", pc_out, 8'h10);
    checkOutput("rst_empty", {7'b0, ras_empty}, 8'h01);
    checkOutput("rst_full", {7'b0, ras_full}, 8'h00);
    checkOutput("rst_err", {7'b0, ras_err}, 8'h00);
    checkOutput("idle_pc_next", pc_next, 8'h11);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("first_seq", pc_out, 8'h11);

    // Sequential wrap
    applyStimulus(0, 0, 0, 1, 0, 8'hFE, 8'h00);
    checkOutput("jump_fe", pc_out, 8'hFE);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("seq_ff", pc_out, 8'hFF);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("seq_wrap_00", pc_out, 8'h00);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("seq_01", pc_out, 8'h01);

    // Relative branches
    applyStimulus(0, 0, 0, 1, 0, 8'h05, 8'h00);
    applyStimulus(0, 0, 0, 0, 1, 8'h00, 8'hFC);
    checkOutput("branch_neg4", pc_out, 8'h01);
    applyStimulus(0, 0, 0, 1, 0, 8'hF0, 8'h00);
    applyStimulus(0, 0, 0, 0, 1, 8'h00, 8'h7F);
    checkOutput("branch_7f_wrap", pc_out, 8'h6F);

    // Nested call / return
    applyStimulus(0, 0, 0, 1, 0, 8'h20, 8'h00);
    applyStimulus(0, 0, 1, 0, 0, 8'h80, 8'h00);
    checkOutput("call1_pc", pc_out, 8'h80);
    checkOutput("call1_empty", {7'b0, ras_empty}, 8'h00);
    applyStimulus(0, 0, 1, 0, 0, 8'h90, 8'h00);
    checkOutput("call2_pc", pc_out, 8'h90);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("ret1_pc", pc_out, 8'h81);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("ret2_pc", pc_out, 8'h21);
    checkOutput("ret2_empty", {7'b0, ras_empty}, 8'h01);
    checkOutput("nested_err", {7'b0, ras_err}, 8'h00);

    // Overflow: five calls into a four-entry stack
    applyStimulus(0, 0, 0, 1, 0, 8'h40, 8'h00);
    applyStimulus(0, 0, 1, 0, 0, 8'h50, 8'h00);
    applyStimulus(0, 0, 1, 0, 0, 8'h60, 8'h00);
    applyStimulus(0, 0, 1, 0, 0, 8'h70, 8'h00);
    applyStimulus(0, 0, 1, 0, 0, 8'h80, 8'h00);
    checkOutput("four_full", {7'b0, ras_full}, 8'h01);
    checkOutput("four_err", {7'b0, ras_err}, 8'h00);
    applyStimulus(0, 0, 1, 0, 0, 8'h90, 8'h00);
    checkOutput("five_pc", pc_out, 8'h90);
    checkOutput("five_full", {7'b0, ras_full}, 8'h01);
    checkOutput("five_err", {7'b0, ras_err}, 8'h01);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("ovf_ret1", pc_out, 8'h81);
    checkOutput("ovf_ret1_full", {7'b0, ras_full}, 8'h00);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("ovf_ret2", pc_out, 8'h71);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("ovf_ret3", pc_out, 8'h61);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("ovf_ret4", pc_out, 8'h51);
    checkOutput("ovf_drained", {7'b0, ras_empty}, 8'h01);

    // Asynchronous reset mid-run with a live RAS entry
    applyStimulus(0, 0, 1, 0, 0, 8'hA0, 8'h00);
    checkOutput("pre_rst_empty", {7'b0, ras_empty}, 8'h00);
    RST = 1;
    #2;
    checkOutput("async_rst_pc", pc_out, 8'h10);
    checkOutput("async_rst_empty", {7'b0, ras_empty}, 8'h01);
    checkOutput("async_rst_err", {7'b0, ras_err}, 8'h00);
    #1 RST = 0;
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("post_rst_seq", pc_out, 8'h11);

    // Underflow, then stalled and competing requests
    applyStimulus(0, 0, 0, 1, 0, 8'h33, 8'h00);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("udf_pc_hold", pc_out, 8'h33);
    checkOutput("udf_err", {7'b0, ras_err}, 8'h01);
    checkOutput("udf_empty", {7'b0, ras_empty}, 8'h01);
    applyStimulus(0, 0, 1, 0, 0, 8'h50, 8'h00);
    checkOutput("call_after_udf", pc_out, 8'h50);
    stall = 1; ret_en = 1; call_en = 1; jump_addr = 8'h70;
    #1;
    checkOutput("stall_pc_next", pc_next, 8'h34);
    applyStimulus(1, 1, 1, 0, 0, 8'h70, 8'h00);
    checkOutput("stall_pc", pc_out, 8'h50);
    checkOutput("stall_empty", {7'b0, ras_empty}, 8'h00);
    applyStimulus(0, 1, 1, 0, 0, 8'h70, 8'h00);
    checkOutput("ret_beats_call", pc_out, 8'h34);
    checkOutput("call_dropped", {7'b0, ras_empty}, 8'h01);
    applyStimulus(0, 0, 0, 1, 1, 8'h02, 8'h10);
    checkOutput("jump_beats_branch", pc_out, 8'h02);
    checkOutput("err_sticky", {7'b0, ras_err}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
